// File: rtl/arpeggiator.sv
// Four-key arpeggiator: registered keys pass straight through, or, when enabled,
// the held keys are played one at a time in ascending order with a programmable dwell.
module arpeggiator #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             key0,
  input  logic             key1,
  input  logic             key2,
  input  logic             key3,
  input  logic             Enable,
  input  logic [CNT_W-1:0] countermax,
  output logic             out0,
  output logic             out1,
  output logic             out2,
  output logic             out3
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    NOTE0 = 3'd1,
    NOTE1 = 3'd2,
    NOTE2 = 3'd3,
    NOTE3 = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       state_code;
  logic [3:0]       on_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dwell_last;
  logic [1:0]       cur_idx, next_idx, low_idx;
  logic             has_next;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      on_q    <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      on_q    <= {key3, key2, key1, key0};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A countermax of zero behaves as a one-clock dwell.
  assign dwell_last = (countermax == '0) ? '0 : countermax - 1'b1;
  assign state_code = state_q;
  assign cur_idx    = state_code[1:0] - 2'd1;

  // Nearest held key after the current one, wrapping; the current key itself is
  // checked last so a lone held note repeats.
  always_comb begin
    has_next = 1'b0;
    next_idx = cur_idx;
    for (int k = 4; k >= 1; k--) begin
      if (on_q[2'(cur_idx + 2'(k))]) begin
        has_next = 1'b1;
        next_idx = 2'(cur_idx + 2'(k));
      end
    end
  end

  always_comb begin
    low_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (on_q[k]) low_idx = 2'(k);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    if (!Enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (|on_q) state_d = state_t'(3'd1 + {1'b0, low_idx});
        end
        NOTE0, NOTE1, NOTE2, NOTE3: begin
          if (!on_q[cur_idx] || cnt_q >= dwell_last) begin
            cnt_d   = '0;
            state_d = has_next ? state_t'(3'd1 + {1'b0, next_idx}) : IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign {out3, out2, out1, out0} = Enable ?
      {state_q == NOTE3, state_q == NOTE2, state_q == NOTE1, state_q == NOTE0} : on_q;

endmodule

// File: tb/tb_arpeggiator.sv
// Bench for arpeggiator: directed scenarios plus a randomized run, all checked
// against a note-level reference model of held keys, current note and elapsed dwell.
module tb_arpeggiator;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        key0 = 1'b0, key1 = 1'b0, key2 = 1'b0, key3 = 1'b0;
  logic        Enable = 1'b0;
  logic [15:0] countermax = 16'd4;
  logic        out0, out1, out2, out3;

  int n_assert = 0;
  int n_fail   = 0;

  bit [3:0] m_on;
  int       m_note;
  int       m_cnt;

  arpeggiator #(.CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET),
    .key0(key0), .key1(key1), .key2(key2), .key3(key3),
    .Enable(Enable), .countermax(countermax),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3)
  );

  always #5 CLK = ~CLK;

  function automatic int nextHeld(int from);
    for (int k = 1; k <= 4; k++) begin
      if (m_on[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  task automatic modelReset();
    m_on   = 4'b0000;
    m_note = -1;
    m_cnt  = 0;
  endtask

  // One clock edge of the reference: a note plays for D cycles, leaves early if
  // its key (as registered) is gone, and new keys become visible one edge late.
  task automatic modelEdge();
    int d;
    if (!RESET) begin
      modelReset();
      return;
    end
    d = (countermax == 0) ? 1 : int'(countermax);
    if (!Enable) begin
      m_note = -1;
      m_cnt  = 0;
    end else if (m_note < 0) begin
      m_note = nextHeld(3);
      m_cnt  = 0;
    end else if (!m_on[m_note] || m_cnt + 1 >= d) begin
      m_note = nextHeld(m_note);
      m_cnt  = 0;
    end else begin
      m_cnt++;
    end
    m_on = {key3, key2, key1, key0};
  endtask

  function automatic logic [3:0] modelOut();
    if (!Enable) return m_on;
    if (m_note < 0) return 4'b0000;
    return 4'b0001 << m_note;
  endfunction

  task automatic applyStimulus(input logic [3:0] k, input logic en, input logic [15:0] cm);
    key0 = k[0];
    key1 = k[1];
    key2 = k[2];
    key3 = k[3];
    Enable = en;
    countermax = cm;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expected);
    logic [3:0] observed;
    observed = {out3, out2, out1, out0};
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    modelEdge();
    #1;
    checkOutput("model", modelOut());
  endtask

  initial begin
    logic [3:0] observed;
    logic [3:0] k;
    modelReset();

    // Reset with random keys and enable
    #2;
    RESET = 1'b0;
    applyStimulus(4'($urandom), 1'($urandom), 16'd4);
    #1;
    checkOutput("reset_async", 4'b0000);
    modelReset();
    tick();
    tick();
    checkOutput("reset_hold", 4'b0000);

    // Pass-through
    applyStimulus(4'b0101, 1'b0, 16'd4);
    RESET = 1'b1;
    tick();
    checkOutput("pass_0101", 4'b0101);
    applyStimulus(4'b1010, 1'b0, 16'd4);
    tick();
    checkOutput("pass_1010", 4'b1010);

    // Arpeggio over key1/key3, dwell 4
    applyStimulus(4'b1010, 1'b1, 16'd4);
    #1;
    checkOutput("enable_idle", 4'b0000);
    for (int t = 0; t < 16; t++) begin
      tick();
      checkOutput("arp_seq", ((t / 4) % 2 == 0) ? 4'b0010 : 4'b1000);
    end

    // Single held key with countermax 0
    applyStimulus(4'b0100, 1'b1, 16'd0);
    tick();
    tick();
    for (int t = 0; t < 6; t++) begin
      tick();
      checkOutput("single_key", 4'b0100);
    end

    // Mid-dwell release of key1, then lowering countermax below the count
    applyStimulus(4'b0111, 1'b0, 16'd8);
    tick();
    tick();
    Enable = 1'b1;
    for (int t = 0; t < 12; t++) tick();
    checkOutput("note1_cnt3", 4'b0010);
    applyStimulus(4'b0101, 1'b1, 16'd8);
    tick();
    checkOutput("release_edge1", 4'b0010);
    tick();
    checkOutput("release_edge2", 4'b0100);
    tick();
    tick();
    tick();
    countermax = 16'd2;
    tick();
    checkOutput("lower_cmax", 4'b0001);

    // Enable drop is immediate on the outputs
    Enable = 1'b0;
    #1;
    checkOutput("enable_drop", 4'b0101);
    tick();
    Enable = 1'b1;
    tick();
    tick();
    tick();

    // Async reset mid-dwell
    #2;
    RESET = 1'b0;
    #1;
    checkOutput("reset_mid", 4'b0000);
    modelReset();
    tick();
    RESET = 1'b1;
    tick();

    // Randomized run
    k = 4'($urandom);
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(2, 0) == 0) k = 4'($urandom);
      applyStimulus(k,
                    ($urandom_range(15, 0) == 0) ? ~Enable : Enable,
                    ($urandom_range(7, 0) == 0) ? 16'($urandom_range(5, 0)) : countermax);
      if (t % 97 == 50) begin
        RESET = 1'b0;
        #1;
        checkOutput("rand_reset", 4'b0000);
        modelReset();
      end else if (!RESET) begin
        RESET = 1'b1;
      end
      tick();
      if (Enable) begin
        observed = {out3, out2, out1, out0};
        n_assert++;
        assert ($countones(observed) <= 1) else begin
          n_fail++;
          $error("[TB] FAIL onehot: observed %b expected at most one bit", observed);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
